nrzi_tx: RTL and testbench

- Transition-encoding serial transmitter: accepts parallel words over a valid/ready handshake, sends them LSB-first on a single line.
- Line encoding: each '1' bit toggles the line, each '0' bit holds it; one bit per clock.
- Drives the line that the team's transition-detecting Mealy receiver samples; that receiver's registered output pulses high exactly on the '1' bits.

---
 rtl/nrzi_tx.sv | 142 ++++++++++++++
 tb/tb_nrzi_tx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrzi_tx.sv
// nrzi_tx: serial transmitter with transition line encoding.
// A '1' bit toggles line_out and a '0' bit holds it. The block sends one bit per clock, LSB first.
// An optional even-parity bit follows the payload. Words are taken over a valid/ready handshake.
// When data_valid is held high, the next word is accepted on the edge that sends the last bit,
// so consecutive frames leave no idle cycle on the line.
module nrzi_tx #(
    parameter int   DATA_W     = 8,
    parameter int   PAR_EN     = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              line_out,
    output logic              bit_strobe,
    output logic              busy
);

    localparam int N     = DATA_W + PAR_EN;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              line_q, line_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic              ready_s;
    logic              accept_s;

    // Even parity: the XOR of all payload bits.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    // Builds the frame to be shifted LSB-first. When enabled, the parity bit sits above the payload.
    function automatic logic [N-1:0] build_frame(input logic [DATA_W-1:0] word);
        logic [N-1:0] frame;
        frame = '0;
        frame[DATA_W-1:0] = word;
        if (PAR_EN != 0) begin
            frame[N-1] = even_parity(word);
        end else begin
            frame = frame;
        end
        return frame;
    endfunction

    // Ready comes from registered state only. It is held low while reset is asserted.
    always_comb begin
        ready_s = 1'b0;
        if (!reset_n) begin
            ready_s = 1'b0;
        end else if (state_q == ST_IDLE) begin
            ready_s = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s = data_valid & ready_s;

    // Next-state logic: load on accept, otherwise shift one bit per clock until the frame is empty.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        strobe_d = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    sr_d    = build_frame(data_in);
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                line_d   = line_q ^ sr_q[0];
                strobe_d = 1'b1;
                busy_d   = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    if (accept_s) begin
                        sr_d    = build_frame(data_in);
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        sr_d    = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    sr_d  = sr_q >> 1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                sr_d    = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Asynchronous reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            line_q   <= IDLE_LEVEL;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    assign data_ready = ready_s;
    assign line_out   = line_q;
    assign bit_strobe = strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nrzi_tx.sv
// tb_nrzi_tx: self-checking bench for nrzi_tx.
// Instance a has no parity bit and instance p appends a parity bit. The expected line level after
// bit i is the starting level XOR the parity of the number of ones sent so far in the frame.
module tb_nrzi_tx;

    logic       clk;
    logic       reset_n;
    logic [7:0] a_data, p_data;
    logic       a_valid, p_valid;
    logic       a_ready, a_line, a_strobe, a_busy;
    logic       p_ready, p_line, p_strobe, p_busy;

    int   checks;
    int   failures;
    logic m_line_a;
    logic m_line_p;

    nrzi_tx #(.DATA_W(8), .PAR_EN(0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .data_in(a_data), .data_valid(a_valid),
        .data_ready(a_ready), .line_out(a_line), .bit_strobe(a_strobe), .busy(a_busy)
    );

    nrzi_tx #(.DATA_W(8), .PAR_EN(1), .IDLE_LEVEL(1'b0)) dut_p (
        .clk(clk), .reset_n(reset_n), .data_in(p_data), .data_valid(p_valid),
        .data_ready(p_ready), .line_out(p_line), .bit_strobe(p_strobe), .busy(p_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level after bits 0..i of a frame have gone out, starting from a known level.
    function automatic logic level_after(input logic start, input logic [8:0] frame, input int i);
        logic [9:0] mask;
        int ones;
        mask = (10'd1 << (i + 1)) - 10'd1;
        ones = $countones(frame & mask[8:0]);
        return start ^ ones[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_valid = 1'b0; p_valid = 1'b0;
        a_data = 8'h00; p_data = 8'h00;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if ({a_line, a_strobe, a_busy, a_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold_a: got %b expected %b", {a_line, a_strobe, a_busy, a_ready}, 4'b0000);
        end
        checks++;
        if ({p_line, p_strobe, p_busy, p_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold_p: got %b expected %b", {p_line, p_strobe, p_busy, p_ready}, 4'b0000);
        end
        reset_n = 1'b1;
        m_line_a = 1'b0;
        m_line_p = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({a_line, a_strobe, a_busy, a_ready} !== 4'b0001) begin
                failures++;
                $display("FAIL idle_a cycle %0d: got %b expected %b", c, {a_line, a_strobe, a_busy, a_ready}, 4'b0001);
            end
            checks++;
            if ({p_line, p_strobe, p_busy, p_ready} !== 4'b0001) begin
                failures++;
                $display("FAIL idle_p cycle %0d: got %b expected %b", c, {p_line, p_strobe, p_busy, p_ready}, 4'b0001);
            end
        end
    endtask

    // Sends one isolated word on instance a after an idle gap and checks every cycle.
    task automatic run_frame_a(input logic [7:0] w, input int gap);
        logic exp_l;
        for (int g = 0; g < gap; g++) begin
            tick();
            checks++;
            if ({a_line, a_strobe, a_busy, a_ready} !== {m_line_a, 3'b001}) begin
                failures++;
                $display("FAIL gap_a: got %b expected %b", {a_line, a_strobe, a_busy, a_ready}, {m_line_a, 3'b001});
            end
        end
        a_valid = 1'b1;
        a_data  = w;
        tick();
        a_valid = 1'b0;
        a_data  = 8'($urandom);
        checks++;
        if ({a_line, a_strobe, a_busy, a_ready} !== {m_line_a, 3'b000}) begin
            failures++;
            $display("FAIL accept_a %h: got %b expected %b", w, {a_line, a_strobe, a_busy, a_ready}, {m_line_a, 3'b000});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_l = level_after(m_line_a, {1'b0, w}, i);
            checks++;
            if ({a_line, a_strobe, a_busy, a_ready} !== {exp_l, 2'b11, (i >= 6)}) begin
                failures++;
                $display("FAIL frame_a %h bit %0d: got %b expected %b", w, i,
                         {a_line, a_strobe, a_busy, a_ready}, {exp_l, 2'b11, (i >= 6)});
            end
        end
        m_line_a = level_after(m_line_a, {1'b0, w}, 7);
        tick();
        checks++;
        if ({a_line, a_strobe, a_busy, a_ready} !== {m_line_a, 3'b001}) begin
            failures++;
            $display("FAIL end_a %h: got %b expected %b", w, {a_line, a_strobe, a_busy, a_ready}, {m_line_a, 3'b001});
        end
    endtask

    // Sends one isolated word on instance p, whose frame has 9 bits with even parity on top.
    task automatic run_frame_p(input logic [7:0] w, input int gap);
        logic       exp_l;
        logic [8:0] f;
        int         ones;
        ones = $countones(w);
        f = {ones[0], w};
        for (int g = 0; g < gap; g++) tick();
        p_valid = 1'b1;
        p_data  = w;
        tick();
        p_valid = 1'b0;
        p_data  = 8'($urandom);
        for (int i = 0; i < 9; i++) begin
            tick();
            exp_l = level_after(m_line_p, f, i);
            checks++;
            if ({p_line, p_strobe, p_busy, p_ready} !== {exp_l, 2'b11, (i >= 7)}) begin
                failures++;
                $display("FAIL frame_p %h bit %0d: got %b expected %b", w, i,
                         {p_line, p_strobe, p_busy, p_ready}, {exp_l, 2'b11, (i >= 7)});
            end
        end
        m_line_p = level_after(m_line_p, f, 8);
        tick();
        checks++;
        if ({p_line, p_strobe, p_busy, p_ready} !== {m_line_p, 3'b001}) begin
            failures++;
            $display("FAIL end_p %h: got %b expected %b", w, {p_line, p_strobe, p_busy, p_ready}, {m_line_p, 3'b001});
        end
    endtask

    task automatic test_single();
        run_frame_a(8'hA5, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_frame_a(8'($urandom), int'($urandom_range(3, 0)));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [6];
        logic       exp_l;
        logic       exp_r;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        for (int k = 2; k < 6; k++) words[k] = 8'($urandom);
        tick();
        a_valid = 1'b1;
        a_data  = words[0];
        checks++;
        if (a_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_idle: got %b expected %b", a_ready, 1'b1);
        end
        tick();
        a_data = words[1];
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                exp_l = level_after(m_line_a, {1'b0, words[j]}, i);
                exp_r = (i == 6) || (j == 5 && i == 7);
                checks++;
                if ({a_line, a_strobe, a_busy, a_ready} !== {exp_l, 2'b11, exp_r}) begin
                    failures++;
                    $display("FAIL b2b word %0d bit %0d: got %b expected %b", j, i,
                             {a_line, a_strobe, a_busy, a_ready}, {exp_l, 2'b11, exp_r});
                end
                if (i == 6 && j == 5) a_valid = 1'b0;
                if (i == 7 && j + 2 < 6) a_data = words[j + 2];
            end
            m_line_a = level_after(m_line_a, {1'b0, words[j]}, 7);
        end
        tick();
        checks++;
        if ({a_line, a_strobe, a_busy, a_ready} !== {m_line_a, 3'b001}) begin
            failures++;
            $display("FAIL b2b_end: got %b expected %b", {a_line, a_strobe, a_busy, a_ready}, {m_line_a, 3'b001});
        end
    endtask

    task automatic test_parity();
        run_frame_p(8'h07, 1);
        for (int n = 0; n < 6; n++) begin
            run_frame_p(8'($urandom), int'($urandom_range(2, 0)));
        end
    endtask

    task automatic test_stall();
        logic [7:0] w0;
        logic       exp_l;
        w0 = 8'($urandom);
        a_valid = 1'b1;
        a_data  = w0;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_l = level_after(m_line_a, {1'b0, w0}, i);
            checks++;
            if ({a_line, a_strobe, a_busy, a_ready} !== {exp_l, 2'b11, (i == 6)}) begin
                failures++;
                $display("FAIL stall_first bit %0d: got %b expected %b", i,
                         {a_line, a_strobe, a_busy, a_ready}, {exp_l, 2'b11, (i == 6)});
            end
            if (i == 2) begin
                a_valid = 1'b1;
                a_data  = 8'h3C;
            end
            if (i == 7) a_valid = 1'b0;
        end
        m_line_a = level_after(m_line_a, {1'b0, w0}, 7);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_l = level_after(m_line_a, 9'h03C, i);
            checks++;
            if ({a_line, a_strobe, a_busy, a_ready} !== {exp_l, 2'b11, (i >= 6)}) begin
                failures++;
                $display("FAIL stall_second bit %0d: got %b expected %b", i,
                         {a_line, a_strobe, a_busy, a_ready}, {exp_l, 2'b11, (i >= 6)});
            end
        end
        m_line_a = level_after(m_line_a, 9'h03C, 7);
        tick();
        checks++;
        if ({a_line, a_strobe, a_busy, a_ready} !== {m_line_a, 3'b001}) begin
            failures++;
            $display("FAIL stall_end: got %b expected %b", {a_line, a_strobe, a_busy, a_ready}, {m_line_a, 3'b001});
        end
    endtask

    task automatic test_reset_mid_frame();
        a_valid = 1'b1;
        a_data  = 8'hFF;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({a_line, a_strobe, a_busy, a_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_a: got %b expected %b", {a_line, a_strobe, a_busy, a_ready}, 4'b0000);
        end
        checks++;
        if ({p_line, p_strobe, p_busy, p_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_p: got %b expected %b", {p_line, p_strobe, p_busy, p_ready}, 4'b0000);
        end
        tick();
        tick();
        reset_n = 1'b1;
        m_line_a = 1'b0;
        m_line_p = 1'b0;
        run_frame_a(8'h01, 2);
        checks++;
        if (a_line !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_01: got %b expected %b", a_line, 1'b1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_parity();
        test_stall();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
